// File: rtl/axi_gain_ramp.sv
// Sample pass-through register that tags every beat with a slewed Q1.15 gain.
// Optional GAIN_RAMP_PKT_ALIGN_EN holds new targets until the next packet boundary.
module axi_gain_ramp #(
  parameter int          WIDTH     = 32,
  parameter logic [15:0] INIT_GAIN = 16'h7FFF,
  parameter int          DIV_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      target_gain,
  input  logic             target_stb,
  input  logic [15:0]      step,
  input  logic [DIV_W-1:0] ramp_div,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic [15:0]      o_gain,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      cur_gain,
  output logic             ramp_active
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]        state, state_next;
  logic [15:0]       target, target_next;
  logic [15:0]       cur, cur_next, stepped;
  logic [DIV_W-1:0]  presc, presc_next, presc_eff;
  logic              accept, run;
  logic signed [17:0] cur_s, tgt_s, step_s, up, dn;

`ifdef GAIN_RAMP_PKT_ALIGN_EN
  logic pkt_start;
`endif

  assign i_tready = ~o_tvalid | o_tready;
  assign accept   = i_tvalid & i_tready;
  assign cur_gain = cur;

  // One guard bit beyond 17 keeps cur+0xFFFF exact before clamping to the target.
  always_comb begin
    cur_s  = {{2{cur[15]}}, cur};
    tgt_s  = {{2{target[15]}}, target};
    step_s = {2'b00, step};
    up     = cur_s + step_s;
    dn     = cur_s - step_s;
    if (cur_s < tgt_s) begin
      stepped = (up > tgt_s) ? target : up[15:0];
    end else begin
      stepped = (dn < tgt_s) ? target : dn[15:0];
    end
  end

  // The beat's own update uses the old target; a strobe only affects later beats.
  always_comb begin
    presc_eff = presc;
    run       = accept && (state == ST_RAMP);
`ifdef GAIN_RAMP_PKT_ALIGN_EN
    if (state == ST_PEND) begin
      presc_eff = '0;
      run       = accept && pkt_start;
    end
`endif
    cur_next   = cur;
    presc_next = presc_eff;
    if (run) begin
      if (step == 16'd0) begin
        cur_next   = target;
        presc_next = '0;
      end else if (presc_eff == ramp_div) begin
        cur_next   = stepped;
        presc_next = '0;
      end else begin
        presc_next = presc_eff + 1'b1;
      end
    end
    target_next = target_stb ? target_gain : target;
    state_next  = (cur_next != target_next) ? ST_RAMP : ST_IDLE;
`ifdef GAIN_RAMP_PKT_ALIGN_EN
    if (target_stb || ((state == ST_PEND) && !run)) begin
      state_next = ST_PEND;
    end
`endif
    if (state_next != ST_RAMP) begin
      presc_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      target      <= INIT_GAIN;
      cur         <= INIT_GAIN;
      presc       <= '0;
      ramp_active <= 1'b0;
    end else begin
      state       <= state_next;
      target      <= target_next;
      cur         <= cur_next;
      presc       <= presc_next;
      ramp_active <= (state != ST_IDLE);
    end
  end

`ifdef GAIN_RAMP_PKT_ALIGN_EN
  // Reset counts as a packet boundary so a pending ramp can start on the first beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_start <= 1'b1;
    end else if (accept) begin
      pkt_start <= i_tlast;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_gain   <= '0;
      o_tlast  <= 1'b0;
    end else begin
      if (i_tready) begin
        o_tvalid <= i_tvalid;
      end
      if (accept) begin
        o_tdata <= i_tdata;
        o_tlast <= i_tlast;
        o_gain  <= cur;
      end
    end
  end

endmodule

// File: tb/tb_axi_gain_ramp.sv
// Randomised and directed bench for axi_gain_ramp (default build) against an
// integer-arithmetic gain model and a beat scoreboard.
module tb_axi_gain_ramp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] target_gain;
  logic        target_stb;
  logic [15:0] step;
  logic [7:0]  ramp_div;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic [15:0] o_gain;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [15:0] cur_gain;
  logic        ramp_active;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] gain;
  } beat_t;

  beat_t exp_q[$];
  int    m_cur, m_target, m_count;
  logic  m_active;
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [31:0] dcnt = 32'h1000_0000;

  axi_gain_ramp dut (
    .clk(clk), .reset_n(reset_n),
    .target_gain(target_gain), .target_stb(target_stb),
    .step(step), .ramp_div(ramp_div),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_gain(o_gain), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .cur_gain(cur_gain), .ramp_active(ramp_active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cur    = sx16(16'h7FFF);
    m_target = m_cur;
    m_count  = 0;
    m_active = 1'b0;
  endtask

  // One clock of stimulus: drive at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic last,
                               input logic ordy, input logic stb, input logic [15:0] tgt);
    logic  acc, pop;
    int    s;
    beat_t b;
    i_tvalid    = vld;
    i_tdata     = data;
    i_tlast     = last;
    o_tready    = ordy;
    target_stb  = stb;
    target_gain = tgt;
    #1;
    checkOutput("o_tvalid", o_tvalid, exp_q.size() > 0);
    checkOutput("i_tready", i_tready, (exp_q.size() == 0) || ordy);
    if (exp_q.size() > 0) begin
      checkOutput("o_tdata", o_tdata, exp_q[0].data);
      checkOutput("o_tlast", o_tlast, exp_q[0].last);
      checkOutput("o_gain", o_gain, exp_q[0].gain);
    end
    pop = (exp_q.size() > 0) && ordy;
    acc = vld && ((exp_q.size() == 0) || ordy);
    @(posedge clk);
    m_active = (m_cur != m_target);
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      b.data = data;
      b.last = last;
      b.gain = m_cur[15:0];
      exp_q.push_back(b);
      if (m_cur != m_target) begin
        s = int'(step);
        if (s == 0) begin
          m_cur   = m_target;
          m_count = 0;
        end else if (m_count == int'(ramp_div)) begin
          if (m_cur < m_target) m_cur = (m_cur + s > m_target) ? m_target : m_cur + s;
          else                  m_cur = (m_cur - s < m_target) ? m_target : m_cur - s;
          m_count = 0;
        end else begin
          m_count++;
        end
      end
    end
    if (stb) m_target = sx16(tgt);
    if (m_cur == m_target) m_count = 0;
    @(negedge clk);
    checkOutput("cur_gain", cur_gain, m_cur[15:0]);
    checkOutput("ramp_active", ramp_active, m_active);
  endtask

  task automatic send_beat(input logic last);
    dcnt = dcnt + 32'h0001_0003;
    applyStimulus(1'b1, dcnt, last, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic set_target(input logic [15:0] tgt);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, tgt);
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic check_reset_values();
    checkOutput("rst o_tvalid", o_tvalid, 1'b0);
    checkOutput("rst o_tdata", o_tdata, 32'h0);
    checkOutput("rst o_gain", o_gain, 16'h0);
    checkOutput("rst o_tlast", o_tlast, 1'b0);
    checkOutput("rst cur_gain", cur_gain, 16'h7FFF);
    checkOutput("rst ramp_active", ramp_active, 1'b0);
  endtask

  initial begin
    reset_n     = 1'b0;
    target_gain = 16'h0;
    target_stb  = 1'b0;
    step        = 16'h0;
    ramp_div    = 8'h0;
    i_tdata     = 32'h0;
    i_tlast     = 1'b0;
    i_tvalid    = 1'b0;
    o_tready    = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset_n = 1'b1;

    // plain pass-through at the reset gain
    for (int i = 0; i < 4; i++) send_beat(i == 3);
    idle_cycle();

    // ramp down every beat: 7FFF, 7BFF, 77FF, 73FF, 7000, 7000
    step     = 16'h0400;
    ramp_div = 8'd0;
    set_target(16'h7000);
    for (int i = 0; i < 6; i++) send_beat(1'b0);
    idle_cycle();

    // jump to 3000, then ramp to 0 ticking every third beat
    step = 16'h0000;
    set_target(16'h3000);
    send_beat(1'b0);
    step     = 16'h1000;
    ramp_div = 8'd2;
    set_target(16'h0000);
    for (int i = 0; i < 10; i++) send_beat(1'b0);
    idle_cycle();

    // strobe coincident with an accepted beat, then back-pressure toggling
    step     = 16'h0200;
    ramp_div = 8'd1;
    dcnt     = dcnt + 32'h11;
    applyStimulus(1'b1, dcnt, 1'b0, 1'b1, 1'b1, 16'h0A00);
    for (int i = 0; i < 12; i++) begin
      dcnt = dcnt + 32'h7;
      applyStimulus(1'b1, dcnt, i[2], i[0], 1'b0, 16'h0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle_cycle();

    // extremes: 7FFF -> 8000 in one tick, then immediate jump to 1234
    step     = 16'h0000;
    ramp_div = 8'd0;
    set_target(16'h7FFF);
    send_beat(1'b0);
    step = 16'hFFFF;
    set_target(16'h8000);
    send_beat(1'b0);
    send_beat(1'b0);
    step = 16'h0000;
    set_target(16'h1234);
    send_beat(1'b0);
    send_beat(1'b1);
    idle_cycle();

    // randomised traffic, strobes and settings
    for (int i = 0; i < 600; i++) begin
      logic        vld, ordy, stb;
      logic [15:0] tgt;
      vld  = ($urandom_range(0, 4) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      stb  = ($urandom_range(0, 15) == 0);
      tgt  = 16'($urandom);
      if (stb) begin
        case ($urandom_range(0, 3))
          0:       step = 16'h0000;
          1:       step = 16'($urandom_range(1, 16'h0080));
          2:       step = 16'($urandom_range(16'h0100, 16'h2000));
          default: step = 16'hFFFF;
        endcase
        if (m_cur == m_target) ramp_div = 8'($urandom_range(0, 3));
      end
      applyStimulus(vld, 32'($urandom), 1'($urandom), ordy, stb, tgt);
    end
    idle_cycle();

    // asynchronous reset in the middle of a slow ramp with a stalled beat held
    step     = 16'h0001;
    ramp_div = 8'd3;
    set_target(16'h8000);
    for (int i = 0; i < 5; i++) send_beat(1'b0);
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 16'h0);
    i_tvalid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) send_beat(i == 3);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
